// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one synchronous single-port memory; grants are combinational,
// reads return 2 cycles after grant. Optional MEM_ARB_RR_EN selects round-robin conflict resolution.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ARB_RR_EN
    // Set when the fetch port should win the next conflict.
    logic rr_if_pref;
`else
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_cnt;
`endif

    logic              rd1_vld;
    logic              rd1_dm;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
                if (rr_if_pref) if_gnt = 1'b1;
                else            dm_gnt = 1'b1;
`else
                if (starve_cnt == STARVE_LIM) if_gnt = 1'b1;
                else                          dm_gnt = 1'b1;
`endif
            end else begin
                if_gnt = if_req;
                dm_gnt = dm_req;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk1) begin
        if (rst)                  rr_if_pref <= 1'b1;
        else if (if_req && dm_req) rr_if_pref <= ~if_gnt;
    end
`else
    always_ff @(posedge clk1) begin
        if (rst)                   starve_cnt <= '0;
        else if (if_req && !if_gnt) starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
        else                       starve_cnt <= '0;
    end
`endif

    // Stage 1 tracks the read issued to memory, stage 2 is the rvalid pair itself.
    always_ff @(posedge clk1) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd1_vld    <= 1'b0;
            rd1_dm     <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            mem_en  <= if_gnt | dm_gnt;
            mem_we  <= dm_gnt & dm_we;
            if (dm_gnt) begin
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (if_gnt) begin
                mem_addr  <= if_addr;
            end
            rd1_vld   <= if_gnt | (dm_gnt & ~dm_we);
            rd1_dm    <= dm_gnt;
            if_rvalid <= rd1_vld & ~rd1_dm;
            dm_rvalid <= rd1_vld & rd1_dm;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dm_rvalid) dm_rdata_q <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic        clk1 = 1'b0;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    // Behavioural synchronous memory.
    always @(posedge clk1) begin
        if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic test_reset();
        @(negedge clk1);
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1;
        @(negedge clk1);
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, dm_gnt}); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 44'h0) begin failures++; $display("FAIL reset_mem got=%b %b %h %h exp=0", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== 66'h0) begin failures++; $display("FAIL reset_rd got=%b %b %h %h exp=0", if_rvalid, dm_rvalid, if_rdata, dm_rdata); end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic test_fetch_single();
        @(negedge clk1);
        if_req = 1'b1; if_addr = 10'd5;
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b10) begin failures++; $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, dm_gnt}); end
        @(negedge clk1);
        if_req = 1'b0;
        checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin failures++; $display("FAIL fetch_mem got=%b %b %0d exp=1 0 5", mem_en, mem_we, mem_addr); end
        @(negedge clk1);
        checks++; if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h12345678}) begin failures++; $display("FAIL fetch_rdata got=%b %b %h exp=1 0 12345678", if_rvalid, dm_rvalid, if_rdata); end
        @(negedge clk1);
        checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h12345678}) begin failures++; $display("FAIL fetch_hold got=%b %h exp=0 12345678", if_rvalid, if_rdata); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL fetch_idle got=%b exp=0", mem_en); end
    endtask

    task automatic test_store_load();
        @(negedge clk1);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd9; dm_wdata = 32'hDEADBEEF;
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin failures++; $display("FAIL st_gnt got=%b exp=01", {if_gnt, dm_gnt}); end
        @(negedge clk1);
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 10'd9, 32'hDEADBEEF}) begin failures++; $display("FAIL st_mem got=%b %b %0d %h exp=1 1 9 deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
        dm_we = 1'b0;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin failures++; $display("FAIL ld_gnt got=%b exp=1", dm_gnt); end
        @(negedge clk1);
        dm_req = 1'b0;
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'd9}) begin failures++; $display("FAIL ld_mem got=%b %b %0d exp=1 0 9", mem_en, mem_we, mem_addr); end
        checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL st_no_rvalid got=%b exp=0", dm_rvalid); end
        @(negedge clk1);
        checks++; if ({dm_rvalid, if_rvalid, dm_rdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL ld_rdata got=%b %b %h exp=1 0 deadbeef", dm_rvalid, if_rvalid, dm_rdata); end
        @(negedge clk1);
        checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL ld_single got=%b exp=0", dm_rvalid); end
    endtask

    task automatic test_contention();
        logic exp_if;
        logic prev_if;
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 10'd3;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
        prev_if = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk1);
                checks++; if (mem_addr !== (prev_if ? 10'd3 : 10'd7)) begin failures++; $display("FAIL cont_addr k=%0d got=%0d exp=%0d", k, mem_addr, prev_if ? 3 : 7); end
            end
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2 == 0);
`else
            exp_if = (k % 5 == 4);
`endif
            #1;
            checks++; if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin failures++; $display("FAIL cont_gnt k=%0d got=%b exp=%b", k, {if_gnt, dm_gnt}, {exp_if, ~exp_if}); end
            prev_if = exp_if;
        end
        @(negedge clk1);
        if_req = 1'b0; dm_req = 1'b0;
        checks++; if (mem_addr !== (prev_if ? 10'd3 : 10'd7)) begin failures++; $display("FAIL cont_last got=%0d exp=%0d", mem_addr, prev_if ? 3 : 7); end
        repeat (3) @(negedge clk1);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk1);
        if_req = 1'b1; if_addr = 10'd5;
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rmr_gnt got=%b exp=1", if_gnt); end
        @(negedge clk1);
        if_req = 1'b0; rst = 1'b1;
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b00) begin failures++; $display("FAIL rmr_gnt_rst got=%b exp=00", {if_gnt, dm_gnt}); end
        @(negedge clk1);
        checks++; if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== 66'h0) begin failures++; $display("FAIL rmr_rd got=%b %b %h %h exp=0", if_rvalid, dm_rvalid, if_rdata, dm_rdata); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 44'h0) begin failures++; $display("FAIL rmr_mem got=%b %b %h %h exp=0", mem_en, mem_we, mem_addr, mem_wdata); end
        rst = 1'b0;
        @(negedge clk1);
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin failures++; $display("FAIL rmr_after got=%b exp=00", {if_rvalid, dm_rvalid}); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk1);
            if (k >= 2) begin
                checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hA0000000 + 32'(k - 2)}) begin failures++; $display("FAIL b2b_data k=%0d got=%b %h exp=1 %h", k, if_rvalid, if_rdata, 32'hA0000000 + 32'(k - 2)); end
            end
            if (k < 4) begin
                if_req = 1'b1; if_addr = 10'(k);
                #1;
                checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt k=%0d got=%b exp=1", k, if_gnt); end
            end else begin
                if_req = 1'b0;
            end
        end
        @(negedge clk1);
        checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", if_rvalid); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0000000 + 32'(i);
        mem[5] = 32'h12345678;
        mem_rdata = 32'h0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_fetch_single();
        test_store_load();
        test_contention();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
